// File: rtl/sha3_pkg.sv
// Shared SHA3 types: state/lane typedefs, squeeze FSM encoding and lane addressing.
// The WAIT_PERM state only exists when SHA3_SQUEEZE_XOF_EN is defined.
package sha3_pkg;

   localparam int unsigned STATE_SIZE = 1600;
   localparam int unsigned PLANE_SIZE = 320;
   localparam int unsigned LANE_W     = 64;

   typedef logic [0:STATE_SIZE-1] state_t;
   typedef logic [LANE_W-1:0]     lane_t;

`ifdef SHA3_SQUEEZE_XOF_EN
   typedef enum logic [1:0] {IDLE, STREAM, WAIT_PERM} fsm_t;
`else
   typedef enum logic [1:0] {IDLE, STREAM} fsm_t;
`endif

   // Lane k = 5*y + x starts at bit 320*y + 64*x of the state.
   function automatic int unsigned lane_base(input int unsigned k);
      return PLANE_SIZE * (k / 5) + LANE_W * (k % 5);
   endfunction

endpackage

// File: rtl/sha3_squeeze_if.sv
// Squeeze-stage bus: state capture handshake, lane output handshake and XOF control.
interface sha3_squeeze_if;
   import sha3_pkg::*;

   state_t state_in;
   logic   state_valid;
   logic   state_ready;
   lane_t  dout;
   logic   dout_valid;
   logic   dout_ready;
   logic   dout_last;
   logic   perm_req;
   logic   xof_stop;

   modport master (
      input  state_in, state_valid, dout_ready, xof_stop,
      output state_ready, dout, dout_valid, dout_last, perm_req
   );

   modport slave (
      output state_in, state_valid, dout_ready, xof_stop,
      input  state_ready, dout, dout_valid, dout_last, perm_req
   );

endinterface

// File: rtl/sha3_lane_select.sv
// Combinational lane mux: returns lane k of a 1600-bit state with lane[z] = state bit z of that lane.
module sha3_lane_select
   import sha3_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] lane_idx,
   output lane_t      lane
);

   logic [4:0]        idx_c;
   logic [10:0]       base;
   logic [0:LANE_W-1] raw;

   always_comb begin
      // Out-of-range indices read lane 0 and are then forced to zero.
      idx_c = (lane_idx > 5'd24) ? 5'd0 : lane_idx;
      base  = 11'(lane_base(32'(idx_c)));
      raw   = state[base +: LANE_W];
      lane  = {<<{raw}};
      if (lane_idx > 5'd24) lane = '0;
   end

endmodule

// File: rtl/sha3_squeeze.sv
// SHA3 squeeze stage: captures the permuted state and streams digest lanes over valid/ready.
// Define SHA3_SQUEEZE_XOF_EN for SHAKE (unbounded output with PERM_REQ / XOF_STOP).
module sha3_squeeze
   import sha3_pkg::*;
#(
   parameter int RATE_LANES   = 17,
   parameter int DIGEST_LANES = 4
)(
   input logic           clk,
   input logic           rst,
   sha3_squeeze_if.master s
);

   localparam int CNT_W = $clog2(RATE_LANES + 1);

   if (RATE_LANES < 1 || RATE_LANES > 24) begin : g_bad_rate
      $error("sha3_squeeze: RATE_LANES must be in 1..24");
   end
   if (DIGEST_LANES > RATE_LANES) begin : g_bad_digest
      $error("sha3_squeeze: DIGEST_LANES must not exceed RATE_LANES");
   end

   fsm_t             fsm;
   state_t           state_q;
   logic [CNT_W-1:0] lane_cnt;
   logic             state_ready_q;
   logic             dout_valid_q;
   logic             dout_last_q;
   lane_t            lane_sel;
   logic             cap;
   logic             xfer;

   assign cap  = s.state_valid && state_ready_q;
   assign xfer = dout_valid_q && s.dout_ready;

   sha3_lane_select u_lane_select (
      .state    (state_q),
      .lane_idx (5'(lane_cnt)),
      .lane     (lane_sel)
   );

   always_ff @(posedge clk) begin
      if (cap) state_q <= s.state_in;
   end

`ifdef SHA3_SQUEEZE_XOF_EN
   localparam logic [CNT_W-1:0] LAST_RATE = CNT_W'(RATE_LANES - 1);
   logic perm_req_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm           <= IDLE;
         lane_cnt      <= '0;
         state_ready_q <= 1'b0;
         dout_valid_q  <= 1'b0;
         dout_last_q   <= 1'b0;
         perm_req_q    <= 1'b0;
      end else begin
         perm_req_q <= 1'b0;
         case (fsm)
            IDLE, WAIT_PERM: begin
               state_ready_q <= 1'b1;
               if (fsm == WAIT_PERM && s.xof_stop) begin
                  fsm <= IDLE;
               end else if (cap) begin
                  fsm           <= STREAM;
                  lane_cnt      <= '0;
                  state_ready_q <= 1'b0;
                  dout_valid_q  <= 1'b1;
               end
            end
            STREAM: begin
               // Stop beats the end-of-rate permutation request.
               if (s.xof_stop) begin
                  fsm           <= IDLE;
                  dout_valid_q  <= 1'b0;
                  state_ready_q <= 1'b1;
               end else if (xfer) begin
                  if (lane_cnt == LAST_RATE) begin
                     fsm           <= WAIT_PERM;
                     dout_valid_q  <= 1'b0;
                     perm_req_q    <= 1'b1;
                     state_ready_q <= 1'b1;
                  end else begin
                     lane_cnt <= lane_cnt + 1'b1;
                  end
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign s.perm_req  = perm_req_q;
   assign s.dout_last = 1'b0;
`else
   localparam logic [CNT_W-1:0] LAST_DIGEST = CNT_W'(DIGEST_LANES - 1);
   localparam logic             FIRST_LAST  = (DIGEST_LANES == 1);
   logic unused_xof_stop;

   assign unused_xof_stop = s.xof_stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm           <= IDLE;
         lane_cnt      <= '0;
         state_ready_q <= 1'b0;
         dout_valid_q  <= 1'b0;
         dout_last_q   <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               state_ready_q <= 1'b1;
               if (cap) begin
                  fsm           <= STREAM;
                  lane_cnt      <= '0;
                  state_ready_q <= 1'b0;
                  dout_valid_q  <= 1'b1;
                  dout_last_q   <= FIRST_LAST;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (dout_last_q) begin
                     fsm           <= IDLE;
                     dout_valid_q  <= 1'b0;
                     dout_last_q   <= 1'b0;
                     state_ready_q <= 1'b1;
                  end else begin
                     lane_cnt    <= lane_cnt + 1'b1;
                     dout_last_q <= ((lane_cnt + 1'b1) == LAST_DIGEST);
                  end
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign s.perm_req  = 1'b0;
   assign s.dout_last = dout_last_q;
`endif

   assign s.state_ready = state_ready_q;
   assign s.dout_valid  = dout_valid_q;
   assign s.dout        = dout_valid_q ? lane_sel : '0;

endmodule
